// File: rtl/event_window_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : event_window_counter_pkg
//  Description : Shared definitions for the event window counter. Holds the
//                control state encoding used by the top-level FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package event_window_counter_pkg;

    localparam int c_STATE_W = 2;

    // Control states of the window counter
    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

endpackage : event_window_counter_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that stops at all-ones instead of wrapping. A
//                sticky flag records any increment attempted at the maximum.
//  Ports       : clk   - system clock (rising edge)
//                reset - asynchronous active-high reset
//                clear - synchronous clear of count and flag (wins over inc)
//                inc   - increment request for this cycle
//                q     - current count
//                sat   - sticky saturation flag, cleared only by clear/reset
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] c_MAX = {W{1'b1}};

    logic [W-1:0] r_q;
    logic         r_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            r_q   <= '0;
            r_sat <= 1'b0;
        end else if (inc) begin
            if (r_q == c_MAX) begin
                r_sat <= 1'b1;
            end else begin
                r_q <= r_q + W'(1);
            end
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule : sat_counter
`default_nettype wire

// File: rtl/event_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : event_window_counter
//  Description : Counts high cycles of the detector pulse over a programmable
//                window of N clocks and reports the count via valid/ready,
//                with a threshold alarm and a saturation flag.
//  Ports       : clk        - system clock (rising edge)
//                reset      - asynchronous active-high reset
//                clr        - synchronous abort back to IDLE, outputs cleared
//                start      - begin a window (sampled only in IDLE)
//                continuous - restart a window right after each handshake
//                win_len    - window length in cycles (0 treated as 1)
//                thresh     - alarm threshold, sampled at window end
//                event_in   - detector pulse, one count per high cycle
//                out_ready  - consumer accepts the report
//                out_valid  - report available
//                out_data   - event count of the completed window
//                alarm      - out_data >= thresh (unsigned)
//                saturated  - count clipped at its maximum during the window
//                busy       - high while counting or reporting
//  Revision    : 1.0 - initial release
// ============================================================================
module event_window_counter
    import event_window_counter_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             start,
    input  logic             continuous,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] thresh,
    input  logic             event_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_data,
    output logic             alarm,
    output logic             saturated,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] c_WIN_ONE = WIN_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIN_W-1:0] r_win_cnt;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_out_data;
    logic             r_alarm;
    logic             r_saturated;

    logic [CNT_W-1:0] w_count;
    logic             w_sat;
    logic [CNT_W-1:0] w_count_next;
    logic             w_sat_next;
    logic             w_count_max;
    logic [WIN_W-1:0] w_win_load;
    logic             w_in_count;
    logic             w_last;
    logic             w_handshake;
    logic             w_load;

    assign w_in_count  = (r_state == S_COUNT);
    assign w_last      = w_in_count && (r_win_cnt == c_WIN_ONE);
    assign w_handshake = (r_state == S_REPORT) && r_out_valid && out_ready;
    // A new window begins from IDLE on start, or back-to-back after a
    // handshake in continuous mode; both clear the count and reload length.
    assign w_load      = ((r_state == S_IDLE) && start) || (w_handshake && continuous);
    assign w_win_load  = (win_len == '0) ? c_WIN_ONE : win_len;

    // The report is captured on the same edge that takes the final sample,
    // so the registered count is one sample behind; fold that sample in here.
    assign w_count_max  = (w_count == c_CNT_MAX);
    assign w_count_next = (event_in && !w_count_max) ? (w_count + CNT_W'(1)) : w_count;
    assign w_sat_next   = w_sat || (event_in && w_count_max);

    sat_counter #(
        .W (CNT_W)
    ) u_event_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (clr || w_load),
        .inc   (w_in_count && event_in),
        .q     (w_count),
        .sat   (w_sat)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_last) begin
                    w_state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (w_handshake) begin
                    w_state_next = continuous ? S_COUNT : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (clr) begin
            w_state_next = S_IDLE;
        end
    end

    // Window down-counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt <= '0;
        end else if (clr) begin
            r_win_cnt <= '0;
        end else if (w_load) begin
            r_win_cnt <= w_win_load;
        end else if (w_in_count) begin
            r_win_cnt <= r_win_cnt - c_WIN_ONE;
        end
    end

    // Report registers; held stable until the handshake, data held beyond it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_alarm     <= 1'b0;
            r_saturated <= 1'b0;
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_alarm     <= 1'b0;
            r_saturated <= 1'b0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_count_next;
            r_alarm     <= (w_count_next >= thresh);
            r_saturated <= w_sat_next;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign alarm     = r_alarm;
    assign saturated = r_saturated;
    assign busy      = (r_state != S_IDLE);

endmodule : event_window_counter
`default_nettype wire

// File: tb/tb_event_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_window_counter
//  Description : Self-checking bench for event_window_counter (CNT_W = 4 so
//                saturation is reachable). Table-driven cycle vectors plus
//                hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_window_counter;

    localparam int CNT_W = 4;
    localparam int WIN_W = 8;

    logic             clk;
    logic             reset;
    logic             clr;
    logic             start;
    logic             continuous;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] thresh;
    logic             ev;
    logic             out_ready;
    logic             out_valid;
    logic [CNT_W-1:0] out_data;
    logic             alarm;
    logic             saturated;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    event_window_counter #(
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .start      (start),
        .continuous (continuous),
        .win_len    (win_len),
        .thresh     (thresh),
        .event_in   (ev),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .alarm      (alarm),
        .saturated  (saturated),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic             start;
        logic             cont;
        logic [WIN_W-1:0] win_len;
        logic [CNT_W-1:0] thresh;
        logic             ev;
        logic             ready;
        logic             e_valid;
        logic [CNT_W-1:0] e_data;
        logic             e_alarm;
        logic             e_sat;
        logic             e_busy;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic c, input logic s, input logic co,
                                input int wl, input int th, input logic e,
                                input logic r, input logic ev_valid,
                                input int ed, input logic ea, input logic es,
                                input logic eb);
        vec_t v;
        v.clr = c; v.start = s; v.cont = co;
        v.win_len = WIN_W'(wl); v.thresh = CNT_W'(th);
        v.ev = e; v.ready = r;
        v.e_valid = ev_valid; v.e_data = CNT_W'(ed);
        v.e_alarm = ea; v.e_sat = es; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, advance through one rising edge, and leave
    // the caller at the next falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr = 1'b0; start = 1'b0; continuous = 1'b0;
        ev = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        win_len = '0;
        thresh  = '0;
        reset   = 1'b1;

        // Table: basic window, backpressure, start-during-COUNT, win_len = 0
        //              clr st co wl th ev rd | val data al sat busy
        vecs[0]  = mk(0, 1, 0, 4, 2, 0, 0,   0, 0, 0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 4, 2, 1, 0,   0, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 4, 2, 0, 0,   0, 0, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 4, 2, 1, 0,   0, 0, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 4, 2, 1, 0,   1, 3, 1, 0, 1);
        vecs[5]  = mk(0, 0, 0, 4, 2, 1, 0,   1, 3, 1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 4, 2, 0, 0,   1, 3, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 4, 2, 1, 0,   1, 3, 1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 4, 2, 0, 0,   1, 3, 1, 0, 1);
        vecs[9]  = mk(0, 0, 0, 4, 2, 1, 0,   1, 3, 1, 0, 1);
        vecs[10] = mk(0, 0, 0, 4, 2, 0, 1,   0, 3, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 4, 2, 1, 0,   0, 3, 0, 0, 0);
        vecs[12] = mk(0, 1, 0, 2, 3, 1, 0,   0, 3, 0, 0, 1);
        vecs[13] = mk(0, 1, 0, 9, 3, 1, 0,   0, 3, 0, 0, 1);
        vecs[14] = mk(0, 1, 0, 9, 3, 1, 0,   1, 2, 0, 0, 1);
        vecs[15] = mk(0, 1, 0, 9, 3, 0, 1,   0, 2, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 9, 3, 0, 0,   0, 2, 0, 0, 0);
        vecs[17] = mk(0, 1, 0, 0, 1, 0, 0,   0, 2, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 1, 1, 0,   1, 1, 1, 0, 1);
        vecs[19] = mk(0, 0, 0, 0, 1, 0, 1,   0, 1, 0, 0, 0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_data",  int'(out_data),  0);
        chk("reset_alarm", int'(alarm),     0);
        chk("reset_sat",   int'(saturated), 0);
        chk("reset_busy",  int'(busy),      0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 20; i++) begin
            clr = vecs[i].clr; start = vecs[i].start; continuous = vecs[i].cont;
            win_len = vecs[i].win_len; thresh = vecs[i].thresh;
            ev = vecs[i].ev; out_ready = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i),  int'(out_data),  int'(vecs[i].e_data));
            chk($sformatf("vec%0d_busy", i),  int'(busy),      int'(vecs[i].e_busy));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_alarm", i), int'(alarm),     int'(vecs[i].e_alarm));
                chk($sformatf("vec%0d_sat", i),   int'(saturated), int'(vecs[i].e_sat));
            end
        end
        idle_inputs();
        step();

        // Saturation: 20 high samples into a 4-bit count
        start = 1'b1; win_len = 8'd20; thresh = 4'd15; ev = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 19; j++) step();
        chk("sat_valid_early", int'(out_valid), 0);
        step();
        chk("sat_valid", int'(out_valid), 1);
        chk("sat_data",  int'(out_data),  15);
        chk("sat_flag",  int'(saturated), 1);
        chk("sat_alarm", int'(alarm),     1);
        out_ready = 1'b1; ev = 1'b0;
        step();
        chk("sat_hs_valid", int'(out_valid), 0);
        chk("sat_hs_busy",  int'(busy),      0);
        out_ready = 1'b0;

        // Exactly reaching the maximum is not saturation
        start = 1'b1; win_len = 8'd15; thresh = 4'd15; ev = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 15; j++) step();
        chk("max_valid", int'(out_valid), 1);
        chk("max_data",  int'(out_data),  15);
        chk("max_sat",   int'(saturated), 0);
        chk("max_alarm", int'(alarm),     1);
        out_ready = 1'b1; ev = 1'b0;
        step();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a window
        start = 1'b1; win_len = 8'd10; ev = 1'b0;
        step();
        start = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            ev = (j <= 3);
            step();
        end
        chk("rstmid_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", int'(busy),      0);
        chk("rstmid_data", int'(out_data),  0);
        chk("rstmid_valid", int'(out_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        ev = 1'b1;
        begin
            int seen_valid = 0;
            for (int j = 0; j < 12; j++) begin
                step();
                if (out_valid || busy) seen_valid++;
            end
            chk("rstmid_stays_idle", seen_valid, 0);
        end

        // Continuous mode: a 3-cycle window plus one report cycle repeats
        start = 1'b1; continuous = 1'b1; out_ready = 1'b1;
        win_len = 8'd3; thresh = 4'd3; ev = 1'b1;
        step();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            chk($sformatf("cont_valid_%0d", j), int'(out_valid), ((j % 4) == 3) ? 1 : 0);
            if ((j % 4) == 3) chk($sformatf("cont_data_%0d", j), int'(out_data), 3);
        end
        chk("cont_busy", int'(busy), 1);
        continuous = 1'b0;
        for (int j = 13; j <= 15; j++) step();
        chk("cont_last_valid", int'(out_valid), 1);
        step();
        chk("cont_end_busy", int'(busy), 0);

        // clr while a report is pending
        idle_inputs();
        start = 1'b1; win_len = 8'd2; thresh = 4'd1; ev = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("clr_pre_valid", int'(out_valid), 1);
        chk("clr_pre_data",  int'(out_data),  2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_valid", int'(out_valid), 0);
        chk("clr_data",  int'(out_data),  0);
        chk("clr_alarm", int'(alarm),     0);
        chk("clr_busy",  int'(busy),      0);
        step();
        step();
        chk("clr_stays_idle", int'(out_valid | busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_event_window_counter
`default_nettype wire
